// File: rtl/fir_chirp_ctrl_if.sv
// rtl/fir_chirp_ctrl_if.sv - sample stream and FIR-side signals of the chirp sequencer
interface fir_chirp_ctrl_if #(
  parameter int D_W = 8
);
  logic [D_W-1:0] s_data;
  logic           s_vld;
  logic           s_rdy;
  logic [D_W-1:0] fir_data;
  logic           fir_vld;
  logic           fir_rstn;
  logic           fir_out_vld;
  logic           m_last;

  modport slave (
    input  s_data, s_vld, fir_out_vld,
    output s_rdy, fir_data, fir_vld, fir_rstn, m_last
  );

  modport master (
    output s_data, s_vld, fir_out_vld,
    input  s_rdy, fir_data, fir_vld, fir_rstn, m_last
  );
endinterface

// File: rtl/fir_chirp_ctrl.sv
// rtl/fir_chirp_ctrl.sv - per-chirp sequencer feeding a decimating FIR gaplessly
module fir_chirp_ctrl #(
  parameter int D_W      = 8,
  parameter int TAPS     = 32,
  parameter int DECIMATE = 1,
  parameter int N_SAMP   = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  fir_chirp_ctrl_if.slave     bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err
);
  localparam int FIR_LAT = $clog2(TAPS) + 3;
  localparam int N_IN    = N_SAMP + TAPS - 1;
  localparam int N_OUT   = (N_IN + DECIMATE - 1) / DECIMATE;
  localparam int IN_W    = $clog2(N_IN + 1);
  localparam int OUT_W   = $clog2(N_OUT + 1);
  localparam int TMR_W   = $clog2(FIR_LAT + 5);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [TMR_W-1:0] timer;
  logic [D_W-1:0]   fir_data_nxt;
  logic             fir_vld_nxt, fir_rstn_nxt, done_nxt;
  logic             arm, last_samp, last_flush, out_final, timeout;

  assign arm        = (state == IDLE) && start;
  assign last_samp  = (in_cnt == IN_W'(N_SAMP - 1));
  assign last_flush = (in_cnt == IN_W'(N_IN - 1));
  assign out_final  = (out_cnt == OUT_W'(N_OUT)) ||
                      (bus.fir_out_vld && (out_cnt == OUT_W'(N_OUT - 1)));
  assign timeout    = (timer == TMR_W'(FIR_LAT + 3));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_samp) state_nxt = (TAPS > 1) ? FLUSH : DRAIN;
      FLUSH:   if (last_flush) state_nxt = DRAIN;
      DRAIN:   if (out_final || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fir_* and done are registered; this block computes their next values
  always_comb begin
    bus.s_rdy    = (state == RUN);
    busy         = (state != IDLE);
    bus.m_last   = bus.fir_out_vld && busy && (out_cnt == OUT_W'(N_OUT - 1));
    fir_data_nxt = '0;
    fir_vld_nxt  = 1'b0;
    fir_rstn_nxt = 1'b1;
    done_nxt     = 1'b0;
    case (state)
      IDLE:  fir_rstn_nxt = !start;
      RUN: begin
        fir_vld_nxt  = 1'b1;
        fir_data_nxt = bus.s_vld ? bus.s_data : '0;
      end
      FLUSH: fir_vld_nxt = 1'b1;
      DRAIN: done_nxt = out_final || timeout;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.fir_data <= '0;
      bus.fir_vld  <= 1'b0;
      bus.fir_rstn <= 1'b1;
      done         <= 1'b0;
      err          <= 2'b00;
      in_cnt       <= '0;
      out_cnt      <= '0;
      timer        <= '0;
    end else begin
      bus.fir_data <= fir_data_nxt;
      bus.fir_vld  <= fir_vld_nxt;
      bus.fir_rstn <= fir_rstn_nxt;
      done         <= done_nxt;
      timer        <= (state == DRAIN) ? timer + 1'b1 : '0;

      if (arm)                                  in_cnt <= '0;
      else if (state == RUN || state == FLUSH)  in_cnt <= in_cnt + 1'b1;

      // final output wins over a timeout landing in the same cycle
      if (arm)
        out_cnt <= '0;
      else if (busy && bus.fir_out_vld && out_cnt != OUT_W'(N_OUT))
        out_cnt <= out_cnt + 1'b1;

      if (arm)                                   err <= 2'b00;
      else begin
        if (state == RUN && !bus.s_vld)          err[0] <= 1'b1;
        if (state == DRAIN && timeout && !out_final) err[1] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_chirp_ctrl.sv
// tb/tb_fir_chirp_ctrl.sv - scoreboard bench for fir_chirp_ctrl with a behavioural FIR stub
module tb_fir_chirp_ctrl;
  localparam int D_W     = 8;
  localparam int TAPS    = 4;
  localparam int DEC     = 2;
  localparam int N_SAMP  = 8;
  localparam int FIR_LAT = 5;
  localparam int N_IN    = 11;
  localparam int N_OUT   = 6;

  typedef struct {
    int err;
    int busy_cyc;
    int outs;
    int mlast;
  } end_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       busy, done;
  logic [1:0] err;

  fir_chirp_ctrl_if #(.D_W(D_W)) bus ();

  fir_chirp_ctrl #(
    .D_W(D_W), .TAPS(TAPS), .DECIMATE(DEC), .N_SAMP(N_SAMP)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_fir[$];
  end_t exp_end[$];
  int   gap_idx = -1;
  int   base    = 0;
  int   drv_idx = 0;
  logic model_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // FIR stub: emits out_vld FIR_LAT cycles after every DEC-th input, phase reset by fir_rstn
  logic [FIR_LAT-1:0] pipe;
  int                 dcnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn || !bus.fir_rstn) begin
      pipe <= '0;
      dcnt <= 0;
    end else begin
      pipe <= {pipe[FIR_LAT-2:0], bus.fir_vld && (dcnt == 0)};
      if (bus.fir_vld) dcnt <= (dcnt == DEC - 1) ? 0 : dcnt + 1;
    end
  end
  assign bus.fir_out_vld = pipe[FIR_LAT-1] && model_en;

  // sample driver: pushes the expected FIR word as each sample is issued
  initial begin
    bus.s_data = '0;
    bus.s_vld  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn || !bus.s_rdy) begin
        drv_idx    = 0;
        bus.s_vld  = 1'b0;
        bus.s_data = '0;
      end else begin
        bus.s_data = D_W'(base + drv_idx + 1);
        bus.s_vld  = (drv_idx != gap_idx);
        exp_fir.push_back(bus.s_vld ? int'(bus.s_data) : 0);
        if (drv_idx == N_SAMP - 1)
          for (int k = 0; k < TAPS - 1; k++) exp_fir.push_back(0);
        drv_idx++;
      end
    end
  end

  // monitor
  int vld_cnt = 0, busy_cnt = 0, mon_outs = 0, ml_cnt = 0;
  initial begin
    int   e;
    end_t x;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        vld_cnt = 0; busy_cnt = 0; mon_outs = 0; ml_cnt = 0;
      end else begin
        if (bus.fir_vld) begin
          vld_cnt++;
          if (exp_fir.size() == 0) chk("fir_extra", 1, 0);
          else begin
            e = exp_fir.pop_front();
            chk("fir_data", int'(bus.fir_data), e);
          end
        end
        if (bus.m_last) ml_cnt++;
        if (bus.fir_out_vld && busy) begin
          mon_outs++;
          chk("m_last_pos", int'(bus.m_last), int'(mon_outs == N_OUT));
        end
        if (busy) busy_cnt++;
        if (done) begin
          chk("done_busy", int'(busy), 0);
          if (exp_end.size() == 0) chk("done_extra", 1, 0);
          else begin
            x = exp_end.pop_front();
            chk("err", int'(err), x.err);
            chk("fir_vld_cycles", vld_cnt, N_IN);
            chk("busy_cycles", busy_cnt, x.busy_cyc);
            chk("fir_outputs", mon_outs, x.outs);
            chk("m_last_count", ml_cnt, x.mlast);
          end
          vld_cnt = 0; busy_cnt = 0; mon_outs = 0; ml_cnt = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_wait", 0, 1);
  endtask

  task automatic push_end(input int e, input int b, input int o, input int m);
    end_t x;
    x.err = e; x.busy_cyc = b; x.outs = o; x.mlast = m;
    exp_end.push_back(x);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_rdy"},    int'(bus.s_rdy),    0);
    chk({tag, "_fir_vld"},  int'(bus.fir_vld),  0);
    chk({tag, "_fir_data"}, int'(bus.fir_data), 0);
    chk({tag, "_fir_rstn"}, int'(bus.fir_rstn), 1);
    chk({tag, "_m_last"},   int'(bus.m_last),   0);
    chk({tag, "_busy"},     int'(busy),         0);
    chk({tag, "_done"},     int'(done),         0);
    chk({tag, "_err"},      int'(err),          0);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // basic ramp 1..8
    base = 0; gap_idx = -1;
    push_end(0, 17, N_OUT, 1);
    pulse_start();
    wait_done();

    // gap on third RUN cycle
    base = 10; gap_idx = 2;
    push_end(1, 17, N_OUT, 1);
    pulse_start();
    wait_done();
    gap_idx = -1;

    // FIR silent: DRAIN runs to timeout
    base = 20; model_en = 1'b0;
    push_end(2, 8 + 3 + FIR_LAT + 4, 0, 0);
    pulse_start();
    wait_done();
    model_en = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-RUN, then a clean chirp
    base = 30;
    pulse_start();
    for (int i = 0; i < 20 && drv_idx < 4; i++) @(negedge clk);
    chk("mid_run_busy", int'(busy), 1);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("async");
    exp_fir.delete();
    exp_end.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    base = 40;
    push_end(0, 17, N_OUT, 1);
    pulse_start();
    wait_done();

    // start held across two chirps: first with a gap, second must clear err
    base = 50; gap_idx = 1;
    push_end(1, 17, N_OUT, 1);
    push_end(0, 17, N_OUT, 1);
    @(negedge clk) start = 1'b1;
    wait_done();
    gap_idx = -1;
    wait_done();
    start = 1'b0;
    repeat (30) @(negedge clk);

    chk("idle_after_held", int'(busy), 0);
    chk("fir_queue_left", exp_fir.size(), 0);
    chk("end_queue_left", exp_end.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
